burst_mem_slave: RTL and testbench
==================================

# burst_mem_slave

Parametrised, synthesizable burst memory slave on the multiplexed cache-to-memory address/data bus. One address beat is followed by BURST_LEN words, each carried as DATA_WIDTH/BUS_WIDTH bus beats, least-significant slice first. Read latency and all widths are configurable, and optional bounds/alignment checking is available. It replaces the fixed 64-bit/4-word behavioural BRAM model behind the cache line adapter and can be instantiated in both simulation and FPGA builds.

## Interface
- BUS_WIDTH, 32, width of the multiplexed bus in bits
- DATA_WIDTH, 64, memory word width; an integer multiple of BUS_WIDTH (BEATS = DATA_WIDTH/BUS_WIDTH)
- BURST_LEN, 4, words per transaction (power of two, ≥1)
- DEPTH, 1024, words of storage (power of two)
- READ_LATENCY, 1, cycles from the address handshake to the first read beat (≥1)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- read_en_c_to_m  in  1  read request, held for the whole transaction
- write_en_c_to_m  in  1  write request, held for the whole transaction; wins if both are high
- address_on_c_to_m  in  1  bus carries the byte address
- data_on_c_to_m  in  1  bus carries a write beat
- address_data_bus_c_to_m  in  BUS_WIDTH  address/write-data bus
- address_data_bus_m_to_c  out  BUS_WIDTH  read-data bus, registered
- resp_m_to_c  out  1  beat accepted (address/write) or read beat valid
- error  out  1  transaction error flag (see Configuration)

## Operation
- The word index is the byte address divided by DATA_WIDTH/8, modulo DEPTH. Burst word k accesses index+k; the index wraps modulo DEPTH.
- TOTAL = BURST_LEN*BEATS. The beat counter is sized ceil(log2(TOTAL+1)).
- States: IDLE, ADDR, WDATA, RWAIT, RDATA, DONE.
  - IDLE: on read_en or write_en, go to ADDR.
  - ADDR: when address_on is high, resp=1 (combinational) and the address is captured. A write goes to WDATA. A read goes to RDATA if READ_LATENCY=1, otherwise to RWAIT.
  - WDATA: each cycle with data_on high, resp=1 (combinational) and the bus is captured into slice (beat mod BEATS) of the assembly register. On the last slice of a word, the assembled word is written to the array at that same edge. After beat TOTAL-1, go to DONE. If data_on is low, the state is held and no beat is counted.
  - RWAIT: waits READ_LATENCY-1 cycles, then goes to RDATA.
  - RDATA: emits one beat per cycle, with no stalls. The output is the registered slice (beat mod BEATS) of word index+beat/BEATS, and resp=1. After beat TOTAL-1, go to DONE.
  - DONE: lasts one cycle with resp=0, then goes to IDLE. If an enable is still high in IDLE, a new transaction starts (back-to-back requests are allowed).
- address_data_bus_m_to_c is 0 whenever no read beat is valid (never X).
- Reset mid-transaction: the state machine goes to IDLE immediately and all outputs go to 0. A partially assembled write word is discarded. Words already committed stay in the array; the array itself is never reset.
- Deasserting the request enable mid-burst is illegal. The block completes the beat count regardless.

## Timing
- Reset values: resp_m_to_c=0, address_data_bus_m_to_c=0, error=0, state=IDLE.
- Write with default parameters: request in cycle t, ADDR at t+1 (address handshake), 8 data beats at t+2..t+9 if continuous, DONE at t+10.
- Read: address handshake in cycle a. Beat j is valid, with resp=1, in cycle a+READ_LATENCY+j for j=0..TOTAL-1. DONE follows the last beat.
- Read-after-write to the same word in a back-to-back transaction returns the new data.

## Configuration
- Macro: BURST_MEM_ERR_CHECK_EN.
- Defined: at the address handshake, the block checks that the address is aligned to BURST_LEN*DATA_WIDTH/8 bytes and that index+BURST_LEN ≤ DEPTH, with no wrap. On failure:
  - the transaction still runs its full beat count;
  - writes are suppressed;
  - read beats return 0;
  - error=1 during the DONE cycle only.
- Not defined: error is tied to 0, no alignment or range checks are made, and addresses wrap modulo DEPTH.

## Test plan
- Reset: hold rst=0 for 3 cycles mid-write burst, then release -> outputs 0, state IDLE; words committed before reset are still readable.
- Write then read with defaults: write address 0x40 with beats 0x1111_0000..0x1111_0007 -> read of 0x40 returns the same 8 beats in order, first beat exactly 1 cycle after the address handshake.
- READ_LATENCY=3: read address 0x0 -> resp low for 2 cycles after the handshake, then 8 consecutive beats; DONE follows.
- Write stall: deassert data_on for 2 cycles between beats 3 and 4 -> no beat counted, stored word 1 = {beat3, beat2}.
- Wrap, macro off (DEPTH=16): write address 0x70 (index 14) -> words land at indices 14, 15, 0, 1; error stays 0.
- Error, macro on: write address 0x48 (misaligned) -> error=1 for one cycle in DONE and the array is unchanged; read address 0x2000 (out of range) -> 8 beats of 0 and error=1.

Source files
------------

// File: rtl/burst_mem_slave.sv
// Burst memory slave on the multiplexed cache-to-memory bus: one address beat, then BURST_LEN words moved as BUS_WIDTH slices, LSB slice first.
// Define BURST_MEM_ERR_CHECK_EN to enable alignment/range checking with the error flag; otherwise error is tied low and addresses wrap.
module burst_mem_slave #(
    parameter int BUS_WIDTH    = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LEN    = 4,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_en_c_to_m,
    input  logic                 write_en_c_to_m,
    input  logic                 address_on_c_to_m,
    input  logic                 data_on_c_to_m,
    input  logic [BUS_WIDTH-1:0] address_data_bus_c_to_m,
    output logic [BUS_WIDTH-1:0] address_data_bus_m_to_c,
    output logic                 resp_m_to_c,
    output logic                 error
);

    localparam int BEATS      = DATA_WIDTH / BUS_WIDTH;
    localparam int TOTAL      = BURST_LEN * BEATS;
    localparam int CNT_W      = $clog2(TOTAL + 1);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int WAIT_W     = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    localparam logic [WAIT_W-1:0] WAIT_INIT = (READ_LATENCY > 1) ? WAIT_W'(READ_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  BEATS_C   = CNT_W'(BEATS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  handshake, wbeat, chk_fail;
    logic [BUS_WIDTH-1:0]  addr_word;
    logic [IDX_W-1:0]      addr_idx;

    assign handshake = (state_q == S_ADDR) && address_on_c_to_m;
    assign wbeat     = (state_q == S_WDATA) && data_on_c_to_m;
    assign addr_word = address_data_bus_c_to_m / BUS_WIDTH'(WORD_BYTES);
    assign addr_idx  = IDX_W'(addr_word);

`ifdef BURST_MEM_ERR_CHECK_EN
    // Range check uses the full word address, so an index that would only fit after wrapping is rejected.
    logic [BUS_WIDTH:0] end_word;
    assign end_word = {1'b0, addr_word} + (BUS_WIDTH + 1)'(BURST_LEN);
    assign chk_fail = ((address_data_bus_c_to_m % BUS_WIDTH'(BURST_LEN * WORD_BYTES)) != '0)
                   || (end_word > (BUS_WIDTH + 1)'(DEPTH));
    assign error    = (state_q == S_DONE) && err_q;
`else
    assign chk_fail = 1'b0;
    assign error    = 1'b0;
`endif

    // Write path: merge the incoming slice into the assembly word; commit on the last slice.
    logic [CNT_W-1:0]      wslice, woff;
    logic [IDX_W-1:0]      waddr;
    logic [DATA_WIDTH-1:0] wword;
    logic                  mem_we;

    assign wslice = beat_q % BEATS_C;
    assign woff   = beat_q / BEATS_C;
    assign waddr  = idx_q + IDX_W'(woff);
    assign mem_we = wbeat && (wslice == CNT_W'(BEATS - 1)) && !err_q;

    always_comb begin
        wword = asm_q;
        for (int s = 0; s < BEATS; s++) begin
            if (wslice == CNT_W'(s)) wword[s*BUS_WIDTH +: BUS_WIDTH] = address_data_bus_c_to_m;
        end
    end

    // NOTE: the storage array has no reset; committed words must survive a reset, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr] <= wword;
    end

    // Read path: fetch the beat that will be visible next cycle and register it onto the bus.
    logic [CNT_W-1:0]      fbeat, fslice, foff;
    logic [IDX_W-1:0]      fbase, faddr;
    logic [DATA_WIDTH-1:0] fword;
    logic                  rd_load, rd_err;

    assign fbeat   = (state_q == S_RDATA) ? beat_q + CNT_W'(1) : '0;
    assign fslice  = fbeat % BEATS_C;
    assign foff    = fbeat / BEATS_C;
    assign fbase   = handshake ? addr_idx : idx_q;
    assign faddr   = fbase + IDX_W'(foff);
    assign fword   = mem[faddr];
    assign rd_err  = handshake ? chk_fail : err_q;
    assign rd_load = (handshake && !write_en_c_to_m && READ_LATENCY == 1)
                  || (state_q == S_RWAIT && wait_q == '0)
                  || (state_q == S_RDATA && beat_q != LAST_BEAT);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        rdata_d = '0;
        if (rd_load && !rd_err) begin
            for (int s = 0; s < BEATS; s++) begin
                if (fslice == CNT_W'(s)) rdata_d = fword[s*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        asm_d   = asm_q;
        case (state_q)
            S_IDLE: if (read_en_c_to_m || write_en_c_to_m) state_d = S_ADDR;
            S_ADDR: begin
                if (address_on_c_to_m) begin
                    beat_d = '0;
                    idx_d  = addr_idx;
                    wait_d = WAIT_INIT;
                    err_d  = chk_fail;
                    if (write_en_c_to_m)        state_d = S_WDATA;
                    else if (READ_LATENCY == 1) state_d = S_RDATA;
                    else                        state_d = S_RWAIT;
                end
            end
            S_WDATA: begin
                if (data_on_c_to_m) begin
                    beat_d = beat_q + CNT_W'(1);
                    asm_d  = wword;
                    if (beat_q == LAST_BEAT) state_d = S_DONE;
                end
            end
            S_RWAIT: begin
                if (wait_q == '0) begin
                    beat_d  = '0;
                    state_d = S_RDATA;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_RDATA: begin
                beat_d = beat_q + CNT_W'(1);
                if (beat_q == LAST_BEAT) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    assign address_data_bus_m_to_c = rdata_q;
    assign resp_m_to_c = handshake || wbeat || (state_q == S_RDATA);

endmodule

// File: tb/tb_burst_mem_slave.sv
// Directed bench for burst_mem_slave: three instances (defaults, READ_LATENCY=3, DEPTH=16) share one stimulus bus, gated by sel.
module tb_burst_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0, addr_on = 1'b0, data_on = 1'b0;
    logic [31:0] bus_in = '0;
    int          sel = 0;

    logic [2:0]  rd_v, wr_v, ao_v, do_v, resp_v, err_v;
    logic [31:0] out0, out1, out2;
    logic [31:0] rdata;
    logic        resp, err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] wdata [8];
    logic [31:0] expd  [8];

    initial forever #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_v[i] = rd_en   && (sel == i);
            wr_v[i] = wr_en   && (sel == i);
            ao_v[i] = addr_on && (sel == i);
            do_v[i] = data_on && (sel == i);
        end
        resp  = resp_v[sel];
        err   = err_v[sel];
        rdata = (sel == 0) ? out0 : (sel == 1) ? out1 : out2;
    end

    burst_mem_slave u_def (
        .clk(clk), .rst(rst_n),
        .read_en_c_to_m(rd_v[0]), .write_en_c_to_m(wr_v[0]),
        .address_on_c_to_m(ao_v[0]), .data_on_c_to_m(do_v[0]),
        .address_data_bus_c_to_m(bus_in), .address_data_bus_m_to_c(out0),
        .resp_m_to_c(resp_v[0]), .error(err_v[0])
    );

    burst_mem_slave #(.READ_LATENCY(3)) u_lat (
        .clk(clk), .rst(rst_n),
        .read_en_c_to_m(rd_v[1]), .write_en_c_to_m(wr_v[1]),
        .address_on_c_to_m(ao_v[1]), .data_on_c_to_m(do_v[1]),
        .address_data_bus_c_to_m(bus_in), .address_data_bus_m_to_c(out1),
        .resp_m_to_c(resp_v[1]), .error(err_v[1])
    );

    burst_mem_slave #(.DEPTH(16)) u_wrap (
        .clk(clk), .rst(rst_n),
        .read_en_c_to_m(rd_v[2]), .write_en_c_to_m(wr_v[2]),
        .address_on_c_to_m(ao_v[2]), .data_on_c_to_m(do_v[2]),
        .address_data_bus_c_to_m(bus_in), .address_data_bus_m_to_c(out2),
        .resp_m_to_c(resp_v[2]), .error(err_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 8; i++) wdata[i] = base + 32'(i);
    endtask

    task automatic do_write(input int s, input logic [31:0] addr, input int stall_after, input logic exp_err);
        sel = s;
        @(negedge clk); wr_en = 1'b1;
        #1 check("wr_idle_resp", 32'(resp), 32'd0);
        @(negedge clk); addr_on = 1'b1; bus_in = addr;
        #1 check("wr_addr_resp", 32'(resp), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); addr_on = 1'b0; data_on = 1'b1; bus_in = wdata[i];
            #1 check("wr_beat_resp", 32'(resp), 32'd1);
            if (i == stall_after) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk); data_on = 1'b0; bus_in = 32'hDEAD_BEEF;
                    #1 check("wr_stall_resp", 32'(resp), 32'd0);
                end
            end
        end
        @(negedge clk); wr_en = 1'b0; data_on = 1'b0; bus_in = '0;
        #1 check("wr_done_resp", 32'(resp), 32'd0);
        check("wr_done_err", 32'(err), 32'(exp_err));
    endtask

    task automatic do_read(input int s, input logic [31:0] addr, input int lat, input logic exp_err);
        sel = s;
        @(negedge clk); rd_en = 1'b1;
        #1 check("rd_idle_resp", 32'(resp), 32'd0);
        check("rd_idle_data", rdata, 32'd0);
        @(negedge clk); addr_on = 1'b1; bus_in = addr;
        #1 check("rd_addr_resp", 32'(resp), 32'd1);
        check("rd_addr_data", rdata, 32'd0);
        for (int c = 1; c < lat; c++) begin
            @(negedge clk); addr_on = 1'b0; bus_in = '0;
            #1 check("rd_wait_resp", 32'(resp), 32'd0);
            check("rd_wait_data", rdata, 32'd0);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); addr_on = 1'b0; bus_in = '0;
            #1 check("rd_beat_resp", 32'(resp), 32'd1);
            check("rd_beat_data", rdata, exp_err ? 32'd0 : expd[j]);
        end
        @(negedge clk); rd_en = 1'b0;
        #1 check("rd_done_resp", 32'(resp), 32'd0);
        check("rd_done_data", rdata, 32'd0);
        check("rd_done_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        // Power-on reset: every instance idles with all outputs low.
        repeat (3) @(negedge clk);
        #1;
        check("rst_resp0", 32'(resp_v[0]), 32'd0);
        check("rst_data0", out0, 32'd0);
        check("rst_err0", 32'(err_v[0]), 32'd0);
        check("rst_resp1", 32'(resp_v[1]), 32'd0);
        check("rst_data1", out1, 32'd0);
        check("rst_resp2", 32'(resp_v[2]), 32'd0);
        check("rst_data2", out2, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Defaults: write 0x40 (words 8..11), then read it back with latency 1.
        fill(32'h1111_0000);
        do_write(0, 32'h40, -1, 1'b0);
        expd = wdata;
        do_read(0, 32'h40, 1, 1'b0);

        // Write stall of 2 cycles between beats 3 and 4; word 1 must be {beat3, beat2}.
        fill(32'h2222_0000);
        do_write(0, 32'h80, 3, 1'b0);
        expd = wdata;
        do_read(0, 32'h80, 1, 1'b0);

        // READ_LATENCY=3 instance.
        fill(32'h3333_0000);
        do_write(1, 32'h0, -1, 1'b0);
        expd = wdata;
        do_read(1, 32'h0, 3, 1'b0);

        // DEPTH=16: 0x10 fills indices 2..5, 0x70 wraps to 14, 15, 0, 1.
        fill(32'h5555_0000);
        do_write(2, 32'h10, -1, 1'b0);
        fill(32'h4444_0000);
        do_write(2, 32'h70, -1, 1'b0);
        expd = wdata;
        do_read(2, 32'h70, 1, 1'b0);
        for (int i = 0; i < 4; i++) expd[i] = 32'h4444_0004 + 32'(i);
        for (int i = 4; i < 8; i++) expd[i] = 32'h5555_0000 + 32'(i - 4);
        do_read(2, 32'h0, 1, 1'b0);

        // Reset after 3 beats of a write to 0x40: word 8 is committed, word 9 partial and discarded.
        sel = 0;
        @(negedge clk); wr_en = 1'b1;
        @(negedge clk); addr_on = 1'b1; bus_in = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); addr_on = 1'b0; data_on = 1'b1; bus_in = 32'h9999_0000 + 32'(i);
        end
        @(negedge clk); rst_n = 1'b0; bus_in = 32'h9999_0003;
        #1 check("midrst_resp", 32'(resp), 32'd0);
        check("midrst_data", rdata, 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); wr_en = 1'b0; data_on = 1'b0; bus_in = '0;
            #1 check("midrst_hold_resp", 32'(resp), 32'd0);
            check("midrst_hold_data", rdata, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        expd[0] = 32'h9999_0000;
        expd[1] = 32'h9999_0001;
        for (int i = 2; i < 8; i++) expd[i] = 32'h1111_0000 + 32'(i);
        do_read(0, 32'h40, 1, 1'b0);
        fill(32'h3333_0000);
        expd = wdata;
        do_read(1, 32'h0, 3, 1'b0);

`ifdef BURST_MEM_ERR_CHECK_EN
        // Misaligned write is suppressed and flags error; out-of-range read returns zeros.
        fill(32'h6666_0000);
        do_write(0, 32'h48, -1, 1'b1);
        expd[0] = 32'h9999_0000;
        expd[1] = 32'h9999_0001;
        for (int i = 2; i < 8; i++) expd[i] = 32'h1111_0000 + 32'(i);
        do_read(0, 32'h40, 1, 1'b0);
        do_read(0, 32'h2000, 1, 1'b1);
`else
        // Without checking, a misaligned address is accepted and error stays low.
        fill(32'h6666_0000);
        do_write(0, 32'h48, -1, 1'b0);
        expd = wdata;
        do_read(0, 32'h48, 1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
